// File: rtl/ascon_pkg.sv
// Shared types and constant tables for the ASCON substitution layer.
package ascon_pkg;

    localparam int NB_COL = 64;

    typedef logic [NB_COL-1:0] type_state [0:4];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } type_fsm;

    // Index is the column value {x0,x1,x2,x3,x4} with x0 as the MSB.
    localparam logic [4:0] SBOX_FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam logic [4:0] SBOX_INV [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

endpackage

// File: rtl/ascon_sbox_lane.sv
// One 5-bit ASCON S-box column, forward or inverse, by table lookup.
module ascon_sbox_lane
    import ascon_pkg::*;
(
    input  logic       inv_i,
    input  logic [4:0] in_i,
    output logic [4:0] out_i
);

    assign out_i = inv_i ? SBOX_INV[in_i] : SBOX_FWD[in_i];

endmodule

// File: rtl/ascon_sub_layer.sv
// Iterative ASCON substitution layer: LANES S-boxes per cycle sweep the 64
// columns of the 320-bit state in place, behind a valid/ready handshake.
module ascon_sub_layer
    import ascon_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  logic      inv_i,
    input  type_state state_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state state_o
);

    localparam int N_STEP = NB_COL / LANES;
    localparam int STEP_W = (N_STEP > 1) ? $clog2(N_STEP) : 1;

    type_fsm           fsm;
    type_fsm           fsm_nxt;
    type_state         st;
    logic [STEP_W-1:0] step;
    logic              inv_q;
    logic              last_step;
    logic [5:0]        base;
    logic [LANES-1:0]  col_cur [5];
    logic [LANES-1:0]  col_new [5];
    logic [4:0]        lane_in [LANES];
    logic [4:0]        lane_out [LANES];

    assign last_step = (step == STEP_W'(N_STEP - 1));
    assign base      = 6'(32'(step) * LANES);
    assign state_o   = st;

    // Slice the current group of columns out of each word and regroup per lane.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            col_cur[k] = st[k][base +: LANES];
        end
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = {col_cur[0][l], col_cur[1][l], col_cur[2][l],
                          col_cur[3][l], col_cur[4][l]};
        end
    end

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            col_new[k] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 5; k++) begin
                col_new[k][l] = lane_out[l][4-k];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ascon_sbox_lane u_lane (
            .inv_i (inv_q),
            .in_i  (lane_in[g]),
            .out_i (lane_out[g])
        );
    end

    always_comb begin
        fsm_nxt = fsm;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (fsm)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    fsm_nxt = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // The state register only changes on accept and during RUN, so the result
    // stays put through DONE and afterwards in IDLE.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm   <= IDLE;
            step  <= '0;
            inv_q <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                st[k] <= '0;
            end
        end else begin
            fsm <= fsm_nxt;
            case (fsm)
                IDLE: begin
                    if (valid_i) begin
                        st    <= state_i;
                        inv_q <= inv_i;
                        step  <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < 5; k++) begin
                        st[k][base +: LANES] <= col_new[k];
                    end
                    step <= last_step ? '0 : step + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
